seq_bam_mult: RTL and testbench
===============================

Name: seq_bam_mult

Overview:
- Sequential, parametrised broken-array approximate unsigned multiplier.
- Accumulates one partial-product row per cycle, applying the horizontal cut (H_CUT) and vertical cut (V_CUT) masks of the broken-array scheme.
- Carries a per-transaction exact-mode override and valid/ready handshakes on both sides.
- Sits beside the combinational BAM arrays as the area-lean, multi-cycle option for datapaths that tolerate latency.

Parameters:
- WIDTH, 8, operand width in bits; legal values 2..32.
- H_CUT, 1, horizontal cut: rows j < H_CUT are dropped in approximate mode; legal 0..WIDTH-1.
- V_CUT, 12, vertical cut: bits with i+j < V_CUT are dropped in approximate mode; legal 0..2*WIDTH-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  multiplicand, unsigned.
- b  in  WIDTH  multiplier, unsigned; row j = b[j].
- approx_en  in  1  1 = apply H_CUT/V_CUT masks, 0 = exact product; sampled with operands.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out  out  2*WIDTH  product.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Partial-product bit pp(i,j) = a[i] & b[j], weight 2^(i+j).
- Approximate mode includes pp(i,j) only if j >= H_CUT and i+j >= V_CUT.
- Exact mode includes every pp(i,j).
- out = exact arithmetic sum of included bits, full 2*WIDTH width. No bit is forced to 0; no overflow is possible.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: capture a, b, approx_en; clear accumulator; set row index j0 = (approx_en ? H_CUT : 0); go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle adds masked row j (a shifted left by j, bits with i+j < V_CUT zeroed when approx) into a 2*WIDTH accumulator, then increments j.
  - After row WIDTH-1 is added, go to DONE.
  - Row count R = WIDTH-H_CUT (approx) or WIDTH (exact).
- DONE:
  - out_valid=1; out holds the accumulator, stable.
  - On out_ready go to IDLE. in_ready rises the next cycle; there is no same-cycle accept on the result handshake.
- Latency: accept edge at cycle 0; out_valid first high after edge R. One transaction every R+2 cycles with out_ready tied high.
- out_ready while not in DONE: ignored.
- in_valid while not in IDLE: ignored. Operand inputs are don't-care outside the accept cycle.
- Rows with b[j]=0 still consume a cycle; latency is data-independent.
- Reset (asynchronous, any state, including mid-RUN or DONE):
  - state=IDLE, in_ready=1, out_valid=0, busy=0, out=0, accumulator and row index cleared.
  - In-flight transaction is discarded; no out_valid follows.
- Outputs are registered; no combinational path from in_* to out_*.

Test Plan:
- Defaults, approx_en=1, a=255, b=255 -> out=45056 (12288+16384+16384); out_valid exactly 7 cycles after accept.
- Defaults, approx_en=0, a=255, b=255 -> out=65025; out_valid 8 cycles after accept.
- Defaults, approx_en=1, a=3, b=3 -> out=0.
- Defaults, approx_en=1, a=128, b=128 -> out=16384. Repeat with approx_en=0 -> 16384.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE -> out stable, in_ready=0, second in_valid ignored.
  - Release out_ready -> next cycle in_ready=1.
- Assert rst in RUN row 3 -> outputs immediately at reset values. Next transaction a=10, b=20, approx_en=0 -> out=200, no stale result emitted.

Source files
------------

// File: rtl/seq_bam_mult.sv
// Sequential broken-array approximate multiplier. Adds one partial-product row
// per cycle, with optional horizontal and vertical cuts applied per transaction.
module seq_bam_mult #(
  parameter int WIDTH = 8,
  parameter int H_CUT = 1,
  parameter int V_CUT = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               approx_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               busy
);

  localparam int P  = 2 * WIDTH;
  localparam int JW = $clog2(WIDTH + 1);
  // Columns below V_CUT are discarded in approximate mode.
  localparam logic [P-1:0] VMASK = {P{1'b1}} << V_CUT;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [P-1:0]    mcand, acc, row, sum;
  logic [WIDTH-1:0] mplier;
  logic            approx_r;
  logic [JW-1:0]   row_idx;
  logic            last_row;

  assign last_row = (row_idx == JW'(WIDTH - 1));

  // mcand already carries the 2^j weight, so the cut is a fixed column mask.
  always_comb begin
    row = mplier[0] ? mcand : '0;
    if (approx_r) row = row & VMASK;
    sum = acc + row;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last_row) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand    <= '0;
      acc      <= '0;
      mplier   <= '0;
      approx_r <= 1'b0;
      row_idx  <= '0;
      out      <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          acc      <= '0;
          approx_r <= approx_en;
          // Approximate mode skips rows below H_CUT outright.
          mcand    <= approx_en ? (P'(a) << H_CUT) : P'(a);
          mplier   <= approx_en ? (b >> H_CUT) : b;
          row_idx  <= approx_en ? JW'(H_CUT) : '0;
        end
        RUN: begin
          acc     <= sum;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          row_idx <= row_idx + 1'b1;
          if (last_row) out <= sum;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_seq_bam_mult.sv
// Directed bench for seq_bam_mult at default parameters: vector table plus
// backpressure and mid-run reset sequences.
module tb_seq_bam_mult;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           approx_en = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] out;
  logic           busy;

  int checks = 0;
  int fails  = 0;

  seq_bam_mult #(.WIDTH(W), .H_CUT(1), .V_CUT(12)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .approx_en(approx_en), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           ax;
    logic [2*W-1:0] exp_out;
    int             exp_lat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Accept one operand pair; returns edges from accept to out_valid (-1 on timeout).
  task automatic start_and_wait(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                input logic tax, output int lat);
    check("in_ready_before_accept", in_ready, 1);
    a = ta; b = tb_; approx_en = tax; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = '1; b = '1; approx_en = ~tax;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = c; break; end
    end
    if (lat < 0) check("out_valid_timeout", 0, 1);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("in_ready_after_release", in_ready, 1);
    check("out_valid_after_release", out_valid, 0);
  endtask

  initial begin
    int lat;
    logic [2*W-1:0] held;

    vecs[0] = '{8'd255, 8'd255, 1'b1, 16'd45056, 7};
    vecs[1] = '{8'd255, 8'd255, 1'b0, 16'd65025, 8};
    vecs[2] = '{8'd3,   8'd3,   1'b1, 16'd0,     7};
    vecs[3] = '{8'd128, 8'd128, 1'b1, 16'd16384, 7};
    vecs[4] = '{8'd128, 8'd128, 1'b0, 16'd16384, 8};
    vecs[5] = '{8'd255, 8'd1,   1'b1, 16'd0,     7};
    vecs[6] = '{8'd255, 8'd128, 1'b1, 16'd28672, 7};
    vecs[7] = '{8'd255, 8'd128, 1'b0, 16'd32640, 8};

    #12;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_out", out, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      start_and_wait(vecs[i].a, vecs[i].b, vecs[i].ax, lat);
      check($sformatf("vec%0d_out", i), out, vecs[i].exp_out);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_busy", i), busy, 1);
      release_result();
    end

    // Backpressure: result held, in_ready low, extra in_valid ignored.
    start_and_wait(8'd255, 8'd255, 1'b0, lat);
    held = out;
    check("bp_first_out", held, 65025);
    a = 8'd2; b = 8'd2; approx_en = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_out_stable", out, 65025);
      check("bp_out_valid_held", out_valid, 1);
      check("bp_in_ready_low", in_ready, 0);
    end
    in_valid = 1'b0;
    release_result();
    repeat (3) @(posedge clk); #1;
    check("bp_no_second_txn", busy, 0);

    // Reset during RUN row 3 discards the transaction.
    start_and_wait_partial: begin
      a = 8'd255; b = 8'd255; approx_en = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrun_rst_in_ready", in_ready, 1);
      check("midrun_rst_out_valid", out_valid, 0);
      check("midrun_rst_busy", busy, 0);
      check("midrun_rst_out", out, 0);
    end
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("post_rst_no_stale_valid", out_valid, 0);
    end
    start_and_wait(8'd10, 8'd20, 1'b0, lat);
    check("post_rst_out", out, 200);
    check("post_rst_latency", lat, 8);
    release_result();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
